// File: rtl/gray_window_buffer_pkg.sv
// Shared types and gray-level arithmetic for the gray window buffer and the style controller.
package gray_win_pkg;

   localparam int PIX_W = 8;
   localparam int SUM_W = 10;

   typedef enum logic [2:0] {
      TAP_P1, TAP_P2, TAP_P3, TAP_P4,
      TAP_P5, TAP_P6, TAP_P7, TAP_P8
   } tap_e;

   function automatic logic [PIX_W-1:0] gray(input logic [PIX_W-1:0] r,
                                             input logic [PIX_W-1:0] g,
                                             input logic [PIX_W-1:0] b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
      return PIX_W'(sum / SUM_W'(3));
   endfunction

endpackage

// File: rtl/gray_window_buffer_line_ram.sv
// One line of gray storage; rd returns the word at addr as it was before this cycle's write.
module gray_line_ram
   import gray_win_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] d,
   output logic [PIX_W-1:0] rd
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rd = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= d;
   end

endmodule

// File: rtl/gray_window_buffer.sv
// Gray 3x3 neighbourhood generator: raw RGB plus 8 gray taps, 1-cycle latency.
// Optional GRAY_WIN_BORDER_ZERO_EN forces out-of-frame taps to zero.
module gray_window_buffer
   import gray_win_pkg::*;
#(
   parameter int IMG_WIDTH = 640,
   parameter int COL_W     = 12
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iDVAL,
   input  logic             iSOF,
   input  logic [PIX_W-1:0] iR,
   input  logic [PIX_W-1:0] iG,
   input  logic [PIX_W-1:0] iB,
   output logic [PIX_W-1:0] oR,
   output logic [PIX_W-1:0] oG,
   output logic [PIX_W-1:0] oB,
   output logic [PIX_W-1:0] oPrev1,
   output logic [PIX_W-1:0] oPrev2,
   output logic [PIX_W-1:0] oPrev3,
   output logic [PIX_W-1:0] oPrev4,
   output logic [PIX_W-1:0] oPrev5,
   output logic [PIX_W-1:0] oPrev6,
   output logic [PIX_W-1:0] oPrev7,
   output logic [PIX_W-1:0] oPrev8,
   output logic             oDVAL,
   output logic             oWinValid
);

   localparam int RAM_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   logic [COL_W-1:0] col_cnt, col_eff;
   logic [1:0]       row_cnt, row_eff;
   logic             col_last;
   logic [PIX_W-1:0] gray_now, a_rd, b_rd;
   logic [PIX_W-1:0] c0, c1, c2, a0, a1, a2, b0, b1, b2;
   logic [PIX_W-1:0] tap [8];

   always_comb begin
      col_eff  = iSOF ? '0 : col_cnt;
      row_eff  = iSOF ? '0 : row_cnt;
      col_last = (col_eff == COL_W'(IMG_WIDTH - 1));
      gray_now = gray(iR, iG, iB);
   end

   // B is fed with A's pre-write word, so B always lags A by exactly one line.
   gray_line_ram #(.DEPTH(IMG_WIDTH), .AW(RAM_AW)) u_line_a (
      .clk(iCLK), .en(iDVAL), .addr(col_eff[RAM_AW-1:0]), .d(gray_now), .rd(a_rd)
   );

   gray_line_ram #(.DEPTH(IMG_WIDTH), .AW(RAM_AW)) u_line_b (
      .clk(iCLK), .en(iDVAL), .addr(col_eff[RAM_AW-1:0]), .d(a_rd), .rd(b_rd)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         {c0, c1, c2, a0, a1, a2, b0, b1, b2} <= '0;
         oR        <= '0;
         oG        <= '0;
         oB        <= '0;
         oDVAL     <= 1'b0;
         oWinValid <= 1'b0;
      end else begin
         oDVAL <= iDVAL;
         if (iDVAL) begin
            col_cnt <= col_last ? '0 : col_eff + COL_W'(1);
            if (col_last) row_cnt <= (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
            else          row_cnt <= row_eff;
            c0 <= gray_now; c1 <= c0; c2 <= c1;
            a0 <= a_rd;     a1 <= a0; a2 <= a1;
            b0 <= b_rd;     b1 <= b0; b2 <= b1;
            oR <= iR;
            oG <= iG;
            oB <= iB;
            oWinValid <= (col_eff >= COL_W'(2)) && (row_eff == 2'd2);
         end
      end
   end

`ifdef GRAY_WIN_BORDER_ZERO_EN
   logic col_ge1, col_ge2, row_ge1, row_ge2;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         {col_ge1, col_ge2, row_ge1, row_ge2} <= '0;
      end else if (iDVAL) begin
         col_ge1 <= (col_eff >= COL_W'(1));
         col_ge2 <= (col_eff >= COL_W'(2));
         row_ge1 <= (row_eff >= 2'd1);
         row_ge2 <= (row_eff >= 2'd2);
      end
   end
`endif

   always_comb begin
      tap[TAP_P1] = c1;
      tap[TAP_P2] = c2;
      tap[TAP_P3] = a0;
      tap[TAP_P4] = a1;
      tap[TAP_P5] = a2;
      tap[TAP_P6] = b0;
      tap[TAP_P7] = b1;
      tap[TAP_P8] = b2;
`ifdef GRAY_WIN_BORDER_ZERO_EN
      if (!col_ge1) begin tap[TAP_P1] = '0; tap[TAP_P4] = '0; tap[TAP_P7] = '0; end
      if (!col_ge2) begin tap[TAP_P2] = '0; tap[TAP_P5] = '0; tap[TAP_P8] = '0; end
      if (!row_ge1) begin tap[TAP_P3] = '0; tap[TAP_P4] = '0; tap[TAP_P5] = '0; end
      if (!row_ge2) begin tap[TAP_P6] = '0; tap[TAP_P7] = '0; tap[TAP_P8] = '0; end
`endif
   end

   assign oPrev1 = tap[TAP_P1];
   assign oPrev2 = tap[TAP_P2];
   assign oPrev3 = tap[TAP_P3];
   assign oPrev4 = tap[TAP_P4];
   assign oPrev5 = tap[TAP_P5];
   assign oPrev6 = tap[TAP_P6];
   assign oPrev7 = tap[TAP_P7];
   assign oPrev8 = tap[TAP_P8];

endmodule

// File: doc/gray_window_buffer.md
Name: gray_window_buffer

Overview:
Upstream stage of the style controller. Accepts a raster RGB pixel stream, computes the gray level per pixel, and stores the two previous lines of gray in line RAMs. Emits each pixel's raw RGB together with its 8 gray neighbours (prev1..prev8), aligned so the style controller can form a full 3x3 window. The controller derives the newest gray tap from the raw RGB itself.

Parameters:
IMG_WIDTH, 640, active pixels per line; legal range 3..4096.
COL_W, 12, column counter width; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
iCLK  in  1  pixel clock.
iRST  in  1  reset; asynchronous, active-high.
iDVAL  in  1  input pixel valid.
iSOF  in  1  start of frame; qualified by iDVAL, marks pixel (row 0, col 0).
iR  in  8  raw red.
iG  in  8  raw green.
iB  in  8  raw blue.
oR  out  8  registered raw red; feeds rawR.
oG  out  8  registered raw green; feeds rawG.
oB  out  8  registered raw blue; feeds rawB.
oPrev1..oPrev8  out  8 each  gray neighbour taps; feed prev1..prev8.
oDVAL  out  1  output valid.
oWinValid  out  1  high when all 8 taps lie inside the current frame.

Behaviour:
- Gray: g = (R+G+B)/3, using a 10-bit sum and truncating division. Examples: 255,255,255 gives 255; 1,1,0 gives 0.
- Window geometry for the current pixel at (y,x):
  - prev1 = g(y,x-1), prev2 = g(y,x-2)
  - prev3 = g(y-1,x), prev4 = g(y-1,x-1), prev5 = g(y-1,x-2)
  - prev6 = g(y-2,x), prev7 = g(y-2,x-1), prev8 = g(y-2,x-2)
- Storage: two line RAMs of IMG_WIDTH x 8.
  - Line RAM A holds row y-1. Line RAM B holds row y-2.
  - At column x, read the old data before writing. Write A[x] = g(y,x) and B[x] = old A[x].
  - Each stream (current, A-out, B-out) feeds a 2-deep horizontal shift chain that produces the x-1 and x-2 taps.
- Timing: all state advances only on iDVAL=1. Latency is exactly 1 cycle: oDVAL is iDVAL delayed by one cycle.
- oR/oG/oB and all taps update together on the cycle after an accepted pixel. They hold their values while iDVAL=0.
- Counters:
  - Column counter increments per accepted pixel and wraps from IMG_WIDTH-1 to 0.
  - On wrap, the row counter increments and saturates at 2.
  - iSOF with iDVAL forces the accepted pixel to col 0, row 0. The next pixel is col 1. This holds mid-frame too.
- oWinValid (registered with the taps) = (col>=2) && (row>=2) for the accepted pixel.
- Line wrap: the horizontal chains are not flushed. Taps at col 0/1 carry the previous line's tail; oWinValid=0 covers this.
- Reset state:
  - All outputs and counters are 0; shift chains are 0.
  - RAM contents are not reset; stale reads are covered by oWinValid.
  - Reset mid-frame: the next accepted pixel is treated as row 0 / col 0 even without iSOF.
- iSOF without iDVAL is ignored.

Optional Feature:
GRAY_WIN_BORDER_ZERO_EN
- Defined: taps outside the frame are forced to 0 at the output register.
  - col<1 zeroes prev1/4/7; col<2 zeroes prev2/5/8.
  - row<1 zeroes prev3/4/5; row<2 zeroes prev6/7/8.
  - oWinValid is unchanged.
- Undefined: taps pass through raw storage values; no masking logic is built.

Decomposition:
- Package gray_win_pkg holds:
  - PIX_W=8 and SUM_W=10
  - a 3x3 tap index enum (TAP_P1..TAP_P8)
  - a gray function shared with the style controller's now_gray
- Sub-module gray_line_ram (parameter DEPTH): single-port, synchronous read-before-write. It is instantiated twice.

Test Plan:
1. Reset: assert iRST asynchronously mid-stream -> all outputs 0 immediately, oDVAL=0. After release, the first pixel reports oWinValid=0.
2. Gray math: pixel (255,255,255) then (1,1,0) -> after the second pixel's output cycle, oPrev1=255. After a third pixel, oPrev1=0 and oPrev2=255.
3. Alignment with IMG_WIDTH=4: feed R=G=B=10*row+col. At output for pixel value 22, the required response is:
   - oR=22
   - prev1..prev8 = 21,20,12,11,10,2,1,0
   - oWinValid=1
4. Stall: insert 3 idle cycles (iDVAL=0) between pixels 21 and 22 -> taps and oR hold, oDVAL=0 during the gap. Results match scenario 3.
5. Border with IMG_WIDTH=4, pixel (row 2, col 0):
   - oWinValid=0.
   - With GRAY_WIN_BORDER_ZERO_EN: prev1/2/4/5/7/8=0, prev3=10, prev6=0.
   - Without it: prev1=13 (previous line tail).
6. iSOF mid-frame at row 1, col 2 -> that pixel reports oWinValid=0. Row/col restart, and the first valid window appears at (2,2) of the new frame.
